// File: rtl/bcd_pkg.sv
// Shared types and constants for the digit-serial packed-BCD adder.
package bcd_pkg;

    typedef logic [3:0] bcd_digit_t;

    localparam bcd_digit_t BCD_MAX  = 4'd9;
    localparam bcd_digit_t BCD_CORR = 4'b0110;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Nines complement of one digit; keeps invalid digits invalid (10..15 -> 15..10).
    function automatic bcd_digit_t nines_comp(input bcd_digit_t d);
        return BCD_MAX - d;
    endfunction

endpackage

// File: rtl/bcd_digit_add.sv
// Combinational single-digit BCD add with +6 decimal correction.
module bcd_digit_add
    import bcd_pkg::*;
(
    input  bcd_digit_t a_d,
    input  bcd_digit_t b_d,
    input  logic       c_in,
    output bcd_digit_t s_d,
    output logic       c_out,
    output logic       bad
);

    logic [4:0] t;

    assign t     = 5'(a_d) + 5'(b_d) + 5'(c_in);
    assign c_out = (t > 5'(BCD_MAX));
    assign s_d   = t[3:0] + (c_out ? BCD_CORR : 4'd0);
    assign bad   = (a_d > BCD_MAX) || (b_d > BCD_MAX);

endmodule

// File: rtl/bcd_serial_adder.sv
// Digit-serial packed-BCD adder, LSD first, valid/ready on both sides.
// Define BCD_SUB_EN to honour the sub port (nines-complement subtraction).
module bcd_serial_adder
    import bcd_pkg::*;
#(
    parameter int unsigned DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [4*DIGITS-1:0]   a,
    input  logic [4*DIGITS-1:0]   b,
    input  logic                  cin,
    input  logic                  sub,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   sum,
    output logic                  cout,
    output logic                  err
);

    localparam int unsigned W  = 4 * DIGITS;
    localparam int unsigned CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIGITS - 1);

    state_t        state_q, state_d;
    logic [W-1:0]  a_q, a_d;
    logic [W-1:0]  b_q, b_d;
    logic [W-1:0]  sum_q, sum_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          c_q, c_d;
    logic          cout_q, cout_d;
    logic          err_q, err_d;

    logic          accept;
    int unsigned   idx;
    bcd_digit_t    dig_s;
    logic          dig_c;
    logic          dig_bad;

    assign accept = (state_q == IDLE) && in_valid;
    assign idx    = 4 * 32'(cnt_q);

`ifndef BCD_SUB_EN
    logic unused_sub;
    assign unused_sub = sub;
`endif

    bcd_digit_add u_digit (
        .a_d   (a_q[idx +: 4]),
        .b_d   (b_q[idx +: 4]),
        .c_in  (c_q),
        .s_d   (dig_s),
        .c_out (dig_c),
        .bad   (dig_bad)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid)      state_d = RUN;
            RUN:     if (cnt_q == LAST) state_d = DONE;
            DONE:    if (out_ready)     state_d = IDLE;
            default:                    state_d = IDLE;
        endcase
    end

    // Handshake outputs decoded straight from the state register
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE:    in_ready  = 1'b1;
            DONE:    out_valid = 1'b1;
            default: ;
        endcase
    end

    // Datapath: operand capture on accept, one digit per RUN cycle
    always_comb begin
        a_d    = a_q;
        b_d    = b_q;
        sum_d  = sum_q;
        cnt_d  = cnt_q;
        c_d    = c_q;
        cout_d = cout_q;
        err_d  = err_q;
        if (accept) begin
            a_d   = a;
            b_d   = b;
            c_d   = cin;
            cnt_d = '0;
            err_d = 1'b0;
`ifdef BCD_SUB_EN
            if (sub) begin
                for (int i = 0; i < int'(DIGITS); i++) begin
                    b_d[4*i +: 4] = nines_comp(b[4*i +: 4]);
                end
                c_d = ~cin;
            end
`endif
        end else if (state_q == RUN) begin
            sum_d[idx +: 4] = dig_s;
            c_d             = dig_c;
            err_d           = err_q | dig_bad;
            if (cnt_q == LAST) begin
                cout_d = dig_c;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q    <= '0;
            b_q    <= '0;
            sum_q  <= '0;
            cnt_q  <= '0;
            c_q    <= 1'b0;
            cout_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            a_q    <= a_d;
            b_q    <= b_d;
            sum_q  <= sum_d;
            cnt_q  <= cnt_d;
            c_q    <= c_d;
            cout_q <= cout_d;
            err_q  <= err_d;
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;
    assign err  = err_q;

endmodule

// File: tb/tb_bcd_serial_adder.sv
// Self-checking bench for bcd_serial_adder against a decimal-arithmetic model.
module tb_bcd_serial_adder;

    localparam int unsigned DIGITS = 4;
    localparam int unsigned W      = 4 * DIGITS;
    localparam int          MOD    = 10 ** DIGITS;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         err;

    int errors = 0;
    int checks = 0;

    bcd_serial_adder #(.DIGITS(DIGITS)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int bcd2int(input logic [W-1:0] v);
        int r = 0;
        for (int i = DIGITS - 1; i >= 0; i--) r = r * 10 + int'(v[4*i +: 4]);
        return r;
    endfunction

    function automatic logic [W-1:0] int2bcd(input int v);
        logic [W-1:0] r = '0;
        int x = v;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic logic [W-1:0] rand_bcd();
        logic [W-1:0] r = '0;
        for (int i = 0; i < DIGITS; i++) r[4*i +: 4] = 4'($urandom_range(0, 9));
        return r;
    endfunction

    // Decimal reference: whole-number add, or subtract with ten's complement on borrow
    task automatic model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic mcin,
                         input logic msub, output logic [W-1:0] esum, output logic ecout);
        int  s;
        logic do_sub;
        do_sub = 1'b0;
`ifdef BCD_SUB_EN
        do_sub = msub;
`endif
        if (do_sub) begin
            s = bcd2int(ma) - bcd2int(mb) - int'(mcin);
            ecout = (s >= 0);
            if (s < 0) s = s + MOD;
        end else begin
            s = bcd2int(ma) + bcd2int(mb) + int'(mcin);
            ecout = (s >= MOD);
            if (s >= MOD) s = s - MOD;
        end
        esum = int2bcd(s);
    endtask

    // Full transaction from idle (called 1 time unit after a rising edge)
    task automatic run_txn(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tcin,
                           input logic tsub, output logic [W-1:0] rs, output logic rc,
                           output logic re, output int lat);
        check("ready_before_accept", 32'(in_ready), 32'd1);
        a = ta; b = tb_; cin = tcin; sub = tsub; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = W'($urandom); b = W'($urandom); cin = ~tcin; sub = ~tsub;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        rs = sum; rc = cout; re = err;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("idle_after_consume", {30'd0, in_ready, out_valid}, 32'b10);
    endtask

    logic [W-1:0] r_sum, e_sum, hold_sum;
    logic         r_cout, r_err, e_cout, hold_cout, hold_err;
    int           lat;

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        #2;
        check("reset_in_ready", 32'(in_ready), 32'd1);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_sum", 32'(sum), 32'd0);
        check("reset_cout_err", {30'd0, cout, err}, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        run_txn(16'h1234, 16'h5678, 1'b0, 1'b0, r_sum, r_cout, r_err, lat);
        check("d1_sum", 32'(r_sum), 32'h6912);
        check("d1_cout_err", {30'd0, r_cout, r_err}, 32'd0);
        check("d1_latency", 32'(lat), 32'(DIGITS));

        run_txn(16'h9999, 16'h0001, 1'b0, 1'b0, r_sum, r_cout, r_err, lat);
        check("d2_sum", 32'(r_sum), 32'h0000);
        check("d2_cout", 32'(r_cout), 32'd1);

        run_txn(16'h9999, 16'h9999, 1'b1, 1'b0, r_sum, r_cout, r_err, lat);
        check("d3_sum", 32'(r_sum), 32'h9999);
        check("d3_cout", 32'(r_cout), 32'd1);

        run_txn(16'h12A4, 16'h0001, 1'b0, 1'b0, r_sum, r_cout, r_err, lat);
        check("bad_digit_sum", 32'(r_sum), 32'h1305);
        check("bad_digit_cout", 32'(r_cout), 32'd0);
        check("bad_digit_err", 32'(r_err), 32'd1);

        run_txn(16'h0500, 16'h0123, 1'b0, 1'b1, r_sum, r_cout, r_err, lat);
`ifdef BCD_SUB_EN
        check("sub1_sum", 32'(r_sum), 32'h0377);
        check("sub1_cout", 32'(r_cout), 32'd1);
`else
        check("sub1_sum", 32'(r_sum), 32'h0623);
        check("sub1_cout", 32'(r_cout), 32'd0);
`endif

        run_txn(16'h0100, 16'h0200, 1'b0, 1'b1, r_sum, r_cout, r_err, lat);
`ifdef BCD_SUB_EN
        check("sub2_sum", 32'(r_sum), 32'h9900);
        check("sub2_cout", 32'(r_cout), 32'd0);
`else
        check("sub2_sum", 32'(r_sum), 32'h0300);
        check("sub2_cout", 32'(r_cout), 32'd0);
`endif

        // Back-pressure: result frozen, new operands refused while DONE
        a = 16'h4321; b = 16'h1111; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check("bp_latency", 32'(lat), 32'(DIGITS));
        hold_sum = sum; hold_cout = cout; hold_err = err;
        check("bp_sum", 32'(hold_sum), 32'h5432);
        a = 16'h0001; b = 16'h0002; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("bp_hold_sum", 32'(sum), 32'(hold_sum));
            check("bp_hold_flags", {30'd0, cout, err}, {30'd0, hold_cout, hold_err});
            check("bp_handshake", {30'd0, in_ready, out_valid}, 32'b01);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("bp_release_idle", {30'd0, in_ready, out_valid}, 32'b10);
        @(posedge clk); #1;
        check("bp_accept_next", 32'(in_ready), 32'd0);
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check("bp_next_sum", 32'(sum), 32'h0003);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;

        // Asynchronous reset in the middle of RUN
        a = 16'h1234; b = 16'h1111; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("rst_run_handshake", {30'd0, in_ready, out_valid}, 32'b10);
        check("rst_run_sum", 32'(sum), 32'd0);
        check("rst_run_flags", {30'd0, cout, err}, 32'd0);
        #2 rst = 1'b0;
        @(posedge clk); #1;
        run_txn(16'h0001, 16'h0001, 1'b0, 1'b0, r_sum, r_cout, r_err, lat);
        check("post_rst_sum", 32'(r_sum), 32'h0002);
        check("post_rst_cout", 32'(r_cout), 32'd0);

        // Random valid operands against the decimal model
        for (int n = 0; n < 24; n++) begin
            logic [W-1:0] ra, rb;
            logic         rc_in, rsub;
            ra = rand_bcd(); rb = rand_bcd();
            rc_in = 1'($urandom); rsub = 1'($urandom);
            model(ra, rb, rc_in, rsub, e_sum, e_cout);
            run_txn(ra, rb, rc_in, rsub, r_sum, r_cout, r_err, lat);
            check("rand_sum", 32'(r_sum), 32'(e_sum));
            check("rand_cout", 32'(r_cout), 32'(e_cout));
            check("rand_err", 32'(r_err), 32'd0);
            check("rand_latency", 32'(lat), 32'(DIGITS));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bcd_serial_adder.md
# bcd_serial_adder

Digit-serial, parametrised packed-BCD adder that generalises the single-digit BCD adder to DIGITS decimal digits. It processes one digit per clock, least-significant digit first, and applies +6 decimal correction per digit. Operands arrive through a valid/ready input handshake, and results leave through a valid/ready output handshake. It sits between operand registers and the display/accumulator path of the decimal arithmetic datapath.

## Interface
- DIGITS, 4, number of BCD digits per operand (≥1)
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  reset, asynchronous, active-high
- in_valid  input  1  operands presented
- in_ready  output  1  block can accept operands (high only in IDLE)
- a  input  4*DIGITS  packed BCD operand A; digit i is a[4i+3:4i]
- b  input  4*DIGITS  packed BCD operand B
- cin  input  1  carry-in (borrow-in when subtracting)
- sub  input  1  1 = subtract; ignored (treated 0) without BCD_SUB_EN
- out_valid  output  1  result available
- out_ready  input  1  consumer takes result
- sum  output  4*DIGITS  packed BCD result
- cout  output  1  decimal carry-out (add) / no-borrow flag (sub)
- err  output  1  at least one input digit of A or B was >9

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE: in_ready=1.
  - On in_valid&&in_ready, latch a, b, sub and initial carry c, clear digit counter, clear err, go to RUN.
  - Add mode: c=cin.
- RUN: once per cycle for digit i=counter:
  - t = a_i + b_i + c, 5-bit.
  - c_next = (t>9).
  - sum_i = (t + (c_next ? 6 : 0))[3:0].
  - err |= (a_i>9)||(b_i>9).
  - Invalid digits still use the same rule; no saturation.
  - After digit DIGITS-1: cout=c_next, go to DONE.
- DONE: out_valid=1; sum, cout and err are held stable.
  - On out_ready: go to IDLE.
  - While out_valid&&!out_ready, every output is frozen.
- Inputs a, b, cin and sub are sampled only at the accept edge. Later changes are ignored.
- in_valid during RUN/DONE is not accepted; the producer must hold it.
- DIGITS=1: RUN lasts exactly one cycle.

## Timing
- Reset values:
  - state=IDLE, in_ready=1, out_valid=0.
  - sum=0, cout=0, err=0, digit counter=0.
- Reset mid-RUN or mid-DONE aborts the transaction. Outputs take reset values immediately (asynchronously) and no result is produced.
- Latency: accept at edge 0; digits processed at edges 1..DIGITS; out_valid high after edge DIGITS.
- Minimum issue interval: DIGITS+2 cycles (DONE→IDLE takes one edge; no accept in DONE).
- in_ready and out_valid are decoded directly from state registers, with no combinational path from in_valid/out_ready.
- Counter width is $clog2(DIGITS) with a minimum of 1. The counter never wraps within a transaction.

## Configuration
- BCD_SUB_EN defined: sub port is honoured.
  - At accept with sub=1, each b digit is replaced by its nines complement (9−b_i) and c=~cin.
  - Result = a − b − cin.
  - cout=1: no borrow, and sum is the true difference.
  - cout=0: borrow, and sum is the ten's complement 10^DIGITS + a − b − cin.
  - err checks the original b digits.
- BCD_SUB_EN undefined: sub is ignored, there is no complement logic, and the block is an adder only.

## Structure
- Package bcd_pkg holds:
  - bcd_digit_t (4-bit typedef)
  - BCD_MAX=4'd9
  - BCD_CORR=4'b0110
  - state enum typedef (IDLE/RUN/DONE)
- Sub-module bcd_digit_add is combinational and contains the per-digit correction.
  - Inputs: a_d, b_d, c_in.
  - Outputs: s_d, c_out, bad.
  - Instantiated once in bcd_serial_adder; the FSM, shift/index registers and handshake live in the top.

## Test plan
- DIGITS=4, a=0x1234, b=0x5678, cin=0 → sum=0x6912, cout=0, err=0, out_valid exactly 4 cycles after accept edge.
- a=0x9999, b=0x0001, cin=0 → sum=0x0000, cout=1; a=0x9999, b=0x9999, cin=1 → sum=0x9999, cout=1.
- a=0x12A4, b=0x0001 → err=1, sum=0x1305, cout=0.
- out_ready held low 5 cycles in DONE → sum/cout/err stable, in_ready=0, new in_valid not accepted; accepted 1 cycle after out_ready.
- rst pulsed mid-RUN → out_valid=0, in_ready=1 without waiting for clock edge; next transaction 0x0001+0x0001 → 0x0002.
- BCD_SUB_EN, sub=1:
  - a=0x0500, b=0x0123, cin=0 → sum=0x0377, cout=1.
  - a=0x0100, b=0x0200 → sum=0x9900, cout=0.
  - Without macro, the same stimulus adds: 0x0623.
